// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier scheduler: FSM state encoding,
// default operand widths and the result-width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam int MULT_N = 8;
    localparam int MULT_M = 4;
    localparam int RESW   = MULT_N + MULT_M;

    // Product width of an n-bit by m-bit multiply.
    function automatic int resw(input int n, input int m);
        return n + m;
    endfunction

endpackage

// File: rtl/mult_low.sv
// Sequential shift-add multiplier (N x M). A data_rdy pulse loads the
// operands; after M iterations res_rdy pulses high for one cycle with the
// product on res. res holds until the next load.
module mult_low #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           data_rdy,
    input  logic [N-1:0]   mult1,
    input  logic [M-1:0]   mult2,
    output logic           res_rdy,
    output logic [M+N-1:0] res
);

    localparam int W  = M + N;
    localparam int CW = $clog2(M + 1);

    logic [W-1:0]  acc_q;
    logic [W-1:0]  mcand_q;
    logic [M-1:0]  mplier_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic          rdy_q;

    // Load on data_rdy, then one partial product per cycle for M cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else if (data_rdy) begin
            acc_q    <= '0;
            mcand_q  <= W'(mult1);
            mplier_q <= mult2;
            cnt_q    <= '0;
            run_q    <= 1'b1;
            rdy_q    <= 1'b0;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == CW'(M - 1)) begin
                run_q <= 1'b0;
                rdy_q <= 1'b1;
            end
        end else begin
            rdy_q <= 1'b0;
        end
    end

    assign res_rdy = rdy_q;
    assign res     = acc_q;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts one past the
// previous grant and wraps, so the previous winner has lowest priority.
module rr_arbiter #(
    parameter int R  = 4,
    parameter int IW = 2
) (
    input  logic [R-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [R-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);

    logic          found;
    logic [IW-1:0] cand;

    assign any_o = |req_i;

    // Walk requesters from last+1 to last (mod R); first active one wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= R; k++) begin
            cand = IW'((int'(last_i) + k) % R);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one sequential multiplier among R
// requesters. One job in flight at a time; each product is returned to
// its originator with a one-hot pulse, and a watchdog aborts jobs whose
// res_rdy never arrives.
//
// Handshake: a requester holds req_vld and its operands until it sees
// its req_ack bit (one-cycle pulse) and must drop req_vld the following
// cycle; a req_vld still high after that is a fresh request. Operands are
// sampled in IDLE on the grant cycle. rsp_vld is a one-cycle one-hot
// pulse with rsp_res valid in the same cycle; there is no back-pressure.
module mult_sched
    import mult_pkg::*;
#(
    parameter int N       = MULT_N,
    parameter int M       = MULT_M,
    parameter int R       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [R-1:0]         req_vld,
    input  logic [R*N-1:0]       req_mult1,
    input  logic [R*M-1:0]       req_mult2,
    output logic [R-1:0]         req_ack,
    output logic [R-1:0]         rsp_vld,
    output logic [resw(N,M)-1:0] rsp_res,
    output logic                 busy,
    output logic                 err,
    output logic                 mul_data_rdy,
    output logic [N-1:0]         mul_mult1,
    output logic [M-1:0]         mul_mult2,
    input  logic                 mul_res_rdy,
    input  logic [resw(N,M)-1:0] mul_res,
    output state_e               dbg_state
);

    localparam int RW = resw(N, M);
    localparam int IW = (R > 1) ? $clog2(R) : 1;
    localparam int CW = $clog2(TIMEOUT);

    state_e        state_q, state_d;
    logic [IW-1:0] win_q, win_d;
    logic [IW-1:0] last_q, last_d;
    logic [N-1:0]  op1_q, op1_d;
    logic [M-1:0]  op2_q, op2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [R-1:0]  rsp_vld_q, rsp_vld_d;
    logic [RW-1:0] rsp_res_q, rsp_res_d;

    logic [R-1:0]  arb_gnt;
    logic [IW-1:0] arb_idx;
    logic          arb_any;

    rr_arbiter #(
        .R  (R),
        .IW (IW)
    ) u_arb (
        .req_i     (req_vld),
        .last_i    (last_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    // State, operand latch, watchdog and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            win_q     <= '0;
            last_q    <= IW'(R - 1);
            op1_q     <= '0;
            op2_q     <= '0;
            cnt_q     <= '0;
            rsp_vld_q <= '0;
            rsp_res_q <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            last_q    <= last_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            cnt_q     <= cnt_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_res_q <= rsp_res_d;
        end
    end

    // Next-state logic and per-state strobes (ack, data_rdy, err).
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        last_d       = last_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        cnt_d        = cnt_q;
        rsp_vld_d    = '0;
        rsp_res_d    = rsp_res_q;
        req_ack      = '0;
        mul_data_rdy = 1'b0;
        err          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A leftover res_rdy from an aborted job blocks new grants.
                if (!mul_res_rdy && arb_any) begin
                    win_d   = arb_idx;
                    op1_d   = req_mult1[int'(arb_idx)*N +: N];
                    op2_d   = req_mult2[int'(arb_idx)*M +: M];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                req_ack[win_q] = 1'b1;
                mul_data_rdy   = 1'b1;
                last_d         = win_q;
                cnt_d          = '0;
                state_d        = ST_BUSY;
            end
            ST_BUSY: begin
                // A result arriving on the expiry cycle still wins.
                if (mul_res_rdy) begin
                    rsp_res_d        = mul_res;
                    rsp_vld_d[win_q] = 1'b1;
                    state_d          = ST_DRAIN;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err     = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (!mul_res_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign rsp_vld   = rsp_vld_q;
    assign rsp_res   = rsp_res_q;
    assign mul_mult1 = op1_q;
    assign mul_mult2 = op2_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched driving a real mult_low. Expected grants come from
// a round-robin model over the pending-request set; expected products are
// plain a*b pushed into a scoreboard queue at each grant.
module tb_mult_sched;
    import mult_pkg::*;

    localparam int N       = 8;
    localparam int M       = 4;
    localparam int R       = 4;
    localparam int TIMEOUT = 64;
    localparam int RW      = N + M;

    logic             clk = 1'b0;
    logic             rst;
    logic [R-1:0]     req_vld;
    logic [R*N-1:0]   req_mult1;
    logic [R*M-1:0]   req_mult2;
    logic [R-1:0]     req_ack;
    logic [R-1:0]     rsp_vld;
    logic [RW-1:0]    rsp_res;
    logic             busy;
    logic             err;
    logic             mul_data_rdy;
    logic [N-1:0]     mul_mult1;
    logic [M-1:0]     mul_mult2;
    logic             mul_res_rdy;
    logic [RW-1:0]    mul_res;
    state_e           dbg_state;
    logic             mlow_res_rdy;
    logic             tie_low;
    logic             spur;

    logic [N-1:0]     a_op[R];
    logic [M-1:0]     b_op[R];
    logic [R-1:0]     hold;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_last;
    int ack_cyc, rsp_cyc, err_cyc;
    int rsp_cnt = 0;
    int err_cnt = 0;
    logic [RW-1:0] last_res;
    int ack_log[$];
    logic [RW-1:0] rsp_res_log[$];
    int exp_idx_q[$];
    logic [RW-1:0] exp_q[$];

    for (genvar g = 0; g < R; g++) begin : g_pack
        assign req_mult1[g*N +: N] = a_op[g];
        assign req_mult2[g*M +: M] = b_op[g];
    end

    assign mul_res_rdy = (mlow_res_rdy & ~tie_low) | spur;

    always #5 clk = ~clk;

    mult_sched #(.N(N), .M(M), .R(R), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_vld      (req_vld),
        .req_mult1    (req_mult1),
        .req_mult2    (req_mult2),
        .req_ack      (req_ack),
        .rsp_vld      (rsp_vld),
        .rsp_res      (rsp_res),
        .busy         (busy),
        .err          (err),
        .mul_data_rdy (mul_data_rdy),
        .mul_mult1    (mul_mult1),
        .mul_mult2    (mul_mult2),
        .mul_res_rdy  (mul_res_rdy),
        .mul_res      (mul_res),
        .dbg_state    (dbg_state)
    );

    mult_low #(.N(N), .M(M)) u_mlow (
        .clk      (clk),
        .rst      (rst),
        .data_rdy (mul_data_rdy),
        .mult1    (mul_mult1),
        .mult2    (mul_mult2),
        .res_rdy  (mlow_res_rdy),
        .res      (mul_res)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first pending requester after the last grant.
    function automatic int rr_pick(input logic [R-1:0] pend, input int last);
        for (int k = 1; k <= R; k++) begin
            int i = (last + k) % R;
            if (pend[i]) return i;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [R-1:0] v);
        for (int i = 0; i < R; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Advance one cycle, observe at the falling edge, update model/driver.
    task automatic tick();
        int idx;
        int ew;
        @(negedge clk);
        cyc++;
        if (req_ack != 0) begin
            idx = oh_idx(req_ack);
            ew  = rr_pick(req_vld, model_last);
            check("ack_onehot", $countones(req_ack), 1);
            check("ack_winner", idx, ew);
            check("ack_data_rdy", mul_data_rdy, 1);
            check("ack_mult1", mul_mult1, a_op[idx]);
            check("ack_mult2", mul_mult2, b_op[idx]);
            model_last = idx;
            ack_log.push_back(idx);
            ack_cyc = cyc;
            exp_idx_q.push_back(idx);
            exp_q.push_back(RW'(int'(a_op[idx]) * int'(b_op[idx])));
            if (!hold[idx]) req_vld[idx] = 1'b0;
        end
        if (rsp_vld != 0) begin
            idx = oh_idx(rsp_vld);
            check("rsp_onehot", $countones(rsp_vld), 1);
            check("rsp_expected", exp_q.size() > 0, 1);
            rsp_cnt++;
            rsp_cyc  = cyc;
            last_res = rsp_res;
            rsp_res_log.push_back(rsp_res);
            if (exp_q.size() > 0) begin
                check("rsp_owner", idx, exp_idx_q.pop_front());
                check("rsp_product", rsp_res, exp_q.pop_front());
            end
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
            check("err_only_when_stalled", tie_low, 1);
            if (exp_q.size() > 0) begin
                void'(exp_idx_q.pop_front());
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, req_ack, 0);
        check({tag, "_rsp_vld"}, rsp_vld, 0);
        check({tag, "_rsp_res"}, rsp_res, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_data_rdy"}, mul_data_rdy, 0);
        check({tag, "_mult1"}, mul_mult1, 0);
        check({tag, "_mult2"}, mul_mult2, 0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    task automatic do_reset(input int n, input string tag);
        rst     = 1'b1;
        req_vld = '0;
        hold    = '0;
        tie_low = 1'b0;
        spur    = 1'b0;
        repeat (n) tick();
        check_reset_outputs(tag);
        rst = 1'b0;
        exp_q.delete();
        exp_idx_q.delete();
        model_last = R - 1;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while ((req_vld != 0 || exp_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, n < budget, 1);
    endtask

    initial begin
        int s, base, rbase, r0, e0, n;
        int exp_rot[4];
        int exp_fair[4];
        exp_rot  = '{160, 40, 105, 1935};
        exp_fair = '{1, 3, 1, 3};
        model_last = R - 1;
        for (int i = 0; i < R; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
        end

        do_reset(2, "reset");

        // Single request: requester 2, 25 x 5.
        a_op[2] = 8'd25; b_op[2] = 4'd5;
        req_vld = 4'b0100;
        s = cyc;
        wait_done(200, "single");
        check("single_ack_latency", ack_cyc - s, 1);
        check("single_rsp_latency", rsp_cyc - ack_cyc, M + 2);
        check("single_res", last_res, 125);
        check("single_idle_after_drain", cyc - rsp_cyc, 1);

        // Rotation after reset: all four at once.
        do_reset(1, "reset2");
        a_op[0] = 8'd16;  b_op[0] = 4'd10;
        a_op[1] = 8'd10;  b_op[1] = 4'd4;
        a_op[2] = 8'd15;  b_op[2] = 4'd7;
        a_op[3] = 8'd215; b_op[3] = 4'd9;
        base  = ack_log.size();
        rbase = rsp_res_log.size();
        req_vld = 4'b1111;
        wait_done(400, "rotation");
        check("rot_count", ack_log.size() - base, 4);
        if (ack_log.size() - base == 4 && rsp_res_log.size() - rbase == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("rot_order", ack_log[base + k], k);
                check("rot_product", rsp_res_log[rbase + k], exp_rot[k]);
            end
        end

        // Fairness: requesters 1 and 3 keep requesting.
        base = ack_log.size();
        hold = 4'b1010;
        req_vld = 4'b1010;
        n = 0;
        while (ack_log.size() - base < 4 && n < 400) begin
            tick();
            n++;
        end
        check("fair_timeout", n < 400, 1);
        hold = '0;
        req_vld = '0;
        wait_done(200, "fair_drain");
        check("fair_count", ack_log.size() - base, 4);
        if (ack_log.size() - base == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("fair_order", ack_log[base + k], exp_fair[k]);
            end
        end

        // Boundary operands.
        a_op[0] = 8'd255; b_op[0] = 4'd15;
        req_vld = 4'b0001;
        wait_done(200, "max");
        check("max_res", last_res, 3825);
        r0 = rsp_cnt;
        a_op[1] = 8'd0; b_op[1] = 4'd9;
        req_vld = 4'b0010;
        wait_done(200, "zero");
        check("zero_rsp_count", rsp_cnt, r0 + 1);
        check("zero_res", last_res, 0);

        // Spurious res_rdy in IDLE blocks grants until it falls.
        base = ack_log.size();
        spur = 1'b1;
        a_op[0] = 8'd3; b_op[0] = 4'd3;
        req_vld = 4'b0001;
        repeat (3) tick();
        check("spur_no_ack", ack_log.size() - base, 0);
        check("spur_idle", dbg_state, ST_IDLE);
        spur = 1'b0;
        wait_done(200, "spur");
        check("spur_res", last_res, 9);

        // Watchdog: multiplier completion hidden from the scheduler.
        tie_low = 1'b1;
        e0 = err_cnt;
        r0 = rsp_cnt;
        a_op[2] = 8'd77; b_op[2] = 4'd3;
        req_vld = 4'b0100;
        n = 0;
        while (err_cnt == e0 && n < 300) begin
            tick();
            n++;
        end
        check("wd_fired", err_cnt, e0 + 1);
        check("wd_latency", err_cyc - ack_cyc, TIMEOUT);
        tick();
        check("wd_err_width", err, 0);
        check("wd_drain_busy", busy, 1);
        tick();
        check("wd_back_idle", dbg_state, ST_IDLE);
        check("wd_busy_low", busy, 0);
        tie_low = 1'b0;
        check("wd_no_rsp", rsp_cnt, r0);
        a_op[3] = 8'd200; b_op[3] = 4'd11;
        req_vld = 4'b1000;
        wait_done(200, "wd_next");
        check("wd_next_res", last_res, 2200);

        // Reset while the multiplier is working.
        a_op[3] = 8'd215; b_op[3] = 4'd9;
        req_vld = 4'b1000;
        base = ack_log.size();
        n = 0;
        while (ack_log.size() == base && n < 50) begin
            tick();
            n++;
        end
        check("midrst_ack_seen", ack_log.size() - base, 1);
        tick();
        tick();
        check("midrst_in_busy", dbg_state, ST_BUSY);
        r0 = rsp_cnt;
        do_reset(1, "midrst");
        req_vld = 4'b1000;
        wait_done(200, "midrst_retry");
        check("midrst_rsp_count", rsp_cnt, r0 + 1);
        check("midrst_res", last_res, 1935);

        // Random request sets and operands.
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < R; i++) begin
                a_op[i] = N'($urandom_range(0, 255));
                b_op[i] = M'($urandom_range(0, 15));
            end
            req_vld = R'($urandom_range(1, 15));
            wait_done(600, "random");
        end
        check("no_errors_untied", err_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=%0d expected_cycles_below=50000", cyc);
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/mult_sched.md
# mult_sched

Round-robin scheduler that shares one sequential `mult_low` multiplier (N-bit × M-bit, `data_rdy`/`res_rdy` handshake) among R requesters. It accepts operand requests and issues one multiply at a time. It returns each product to its originator with a one-hot response pulse and guards the multiplier with a completion watchdog. It sits between the client blocks and a single `mult_low` instance, which it drives directly.

## Interface
- `N`, 8, width of multiplicand `mult1`
- `M`, 4, width of multiplier `mult2`
- `R`, 4, number of requesters (≥2)
- `TIMEOUT`, 64, max cycles to wait for `res_rdy` before abort (≥ M+4)

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_vld`  in  R  per-requester request; held with operands until acked
- `req_mult1`  in  R*N  packed operands, requester i at [i*N +: N]
- `req_mult2`  in  R*M  packed operands, requester i at [i*M +: M]
- `req_ack`  out  R  one-hot, 1-cycle pulse: request accepted
- `rsp_vld`  out  R  one-hot, 1-cycle pulse: product valid for requester i
- `rsp_res`  out  M+N  product, valid while any `rsp_vld` bit high
- `busy`  out  1  high in every state except IDLE
- `err`  out  1  1-cycle pulse on watchdog abort
- `mul_data_rdy`  out  1  to `mult_low.data_rdy`
- `mul_mult1`  out  N  to `mult_low.mult1`
- `mul_mult2`  out  M  to `mult_low.mult2`
- `mul_res_rdy`  in  1  from `mult_low.res_rdy`
- `mul_res`  in  M+N  from `mult_low.res`

## Operation
- FSM states: IDLE, ISSUE, BUSY, DRAIN.
- IDLE:
  - Stays put while `mul_res_rdy`=1.
  - Otherwise, if any `req_vld` is high, selects winner w by round-robin. Search starts at `last+1` mod R, where `last` is the previous grant; `last` resets to R-1, so requester 0 has top priority after reset.
  - Latches w, `req_mult1[w]`, `req_mult2[w]` and moves to ISSUE.
- ISSUE, exactly 1 cycle:
  - `mul_data_rdy`=1, `req_ack[w]`=1, `last`←w.
  - Moves to BUSY and clears the watchdog counter.
- BUSY:
  - `mul_data_rdy`=0.
  - On `mul_res_rdy`=1: capture `mul_res` into `rsp_res`, pulse `rsp_vld[w]` next cycle, go to DRAIN.
  - If the counter reaches TIMEOUT-1 with no `res_rdy`: pulse `err`, no `rsp_vld`, go to DRAIN.
- DRAIN: waits for `mul_res_rdy`=0, then returns to IDLE. The earliest next grant is the cycle after that.
- `mul_mult1`/`mul_mult2` hold the latched operands from ISSUE until the next ISSUE. They never change while the multiplier is busy.
- Requester rules:
  - Deassert `req_vld` the cycle after `req_ack`; a still-high `req_vld` is treated as a new request.
  - Non-winning requesters keep waiting with no ack.
  - Operand changes before ack are legal; the values sampled in IDLE are used.
- Width: `rsp_res` is exactly M+N bits, passed unmodified. The scheduler does no arithmetic on the data.

## Timing
- Reset values: `req_ack`=0, `rsp_vld`=0, `rsp_res`=0, `busy`=0, `err`=0, `mul_data_rdy`=0, `mul_mult1`=0, `mul_mult2`=0, state IDLE, `last`=R-1.
- `rst` mid-operation returns to IDLE on the next edge and drops all outputs to reset values. The multiplier is reset by the same system reset. Any pending request is re-arbitrated afresh.
- Cycle sequence from `req_vld` seen in IDLE at edge t:
  - t+1: ISSUE, ack and `data_rdy` high.
  - t+2 onward: BUSY.
  - `rsp_vld` is high the cycle after the first `mul_res_rdy`=1 seen in BUSY.
- Scheduler overhead: 3 cycles plus multiplier latency plus DRAIN length.
- Simultaneous events:
  - `mul_res_rdy` and watchdog expiry on the same cycle → the result wins, no `err`.
  - All R requesting → grants rotate 0,1,…,R-1,0.
  - A single requester requesting repeatedly → granted every transaction.
- Spurious `mul_res_rdy` in IDLE or ISSUE is ignored; IDLE does not grant until it falls.

## Structure
- Shared package `mult_pkg`: FSM state enum, `MULT_N`/`MULT_M` defaults, `RESW = M+N` helper.
- Sub-module `rr_arbiter` (R request bits, `last` pointer in → one-hot grant, grant index). It is combinational and reusable.
- The FSM, operand latch, watchdog counter ($clog2(TIMEOUT) bits) and response register live in `mult_sched`.
- The bench instantiates `mult_sched` plus a real `mult_low`.

## Test plan
- Single request: requester 2 sends 25×5 → one `req_ack[2]` pulse, later `rsp_vld`=4'b0100 with `rsp_res`=125, `busy` low after DRAIN.
- Rotation: all four request at once with 16×10, 10×4, 15×7, 215×9 → acks in order 0,1,2,3; products 160, 40, 105, 1935, each tagged to the correct requester.
- Fairness: requesters 1 and 3 hold `req_vld` continuously → grants alternate 1,3,1,3 over 4 transactions.
- Boundary operands: 255×15 → 3825; 0×9 → 0; results are 12-bit and exact.
- Watchdog: tie `mul_res_rdy` low → `err` pulses exactly TIMEOUT cycles after ISSUE, no `rsp_vld`, scheduler back in IDLE and accepts the next request.
- Reset mid-BUSY: assert `rst` for 1 cycle during a 215×9 job → all outputs 0 next cycle; the re-presented request completes with 1935.
